// File: rtl/expr_eval_pipe.sv
// expr_eval_pipe: valid/ready, 2-stage evaluator of Verilog-semantics expressions on WIDTH-bit operands.
// Define EXPR_EVAL_DIV_EN to build the iterative DIV/MOD unit; without it opcodes 12/13 are illegal.
module expr_eval_pipe #(
  parameter int WIDTH = 8,
  parameter int RW    = 2 * WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic             a_signed,
  input  logic [WIDTH-1:0] b,
  input  logic             b_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RW-1:0]    result,
  output logic             err
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_MUL  = 4'd2,  OP_AND  = 4'd3,
    OP_OR   = 4'd4,  OP_XNOR = 4'd5,  OP_SHL  = 4'd6,  OP_SHR  = 4'd7,
    OP_LT   = 4'd8,  OP_EQ   = 4'd9,  OP_RAND = 4'd10, OP_RXOR = 4'd11,
    OP_DIV  = 4'd12, OP_MOD  = 4'd13, OP_IL14 = 4'd14, OP_IL15 = 4'd15
  } op_e;

  typedef enum logic [1:0] {ST_RUN, ST_DIV, ST_DRAIN} state_e;

  state_e          state_q, state_d;
  logic            s1_valid_q, s1_valid_d;
  op_e             s1_op_q, s1_op_d;
  logic            s1_s_q, s1_s_d;
  logic [RW-1:0]   s1_a_q, s1_a_d;
  logic [RW-1:0]   s1_b_q, s1_b_d;
  logic            out_valid_q, out_valid_d;
  logic [RW-1:0]   result_q, result_d;
  logic            err_q, err_d;

  logic            advance;
  logic            accept;
  logic            is_div;
  logic            s_in;
  logic [RW-1:0]   alu_res;
  logic            alu_err;
  logic [63:0]     amt;
  logic            sh_over;
  logic            lt;

`ifdef EXPR_EVAL_DIV_EN
  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]    div_cnt_q, div_cnt_d;
  logic [WIDTH-1:0] div_rem_q, div_rem_d;
  logic [WIDTH-1:0] div_quo_q, div_quo_d;
  logic [WIDTH-1:0] div_den_q, div_den_d;
  logic             div_mod_q, div_mod_d;
  logic             div_qneg_q, div_qneg_d;
  logic             div_rneg_q, div_rneg_d;
  logic             div_zero_q, div_zero_d;
  logic [RW-1:0]    div_a_q, div_a_d;

  logic [WIDTH-1:0] ld_a_low, ld_b_low, ld_a_mag, ld_b_mag;
  logic             ld_a_neg, ld_b_neg;
  logic [WIDTH:0]   rem_shift, trial;
  logic [WIDTH-1:0] rem_nx, quo_nx;
  logic [RW-1:0]    q_ext, r_ext, div_res;
`endif

  assign advance  = !out_valid_q || out_ready;
  assign in_ready = rst_n && (state_q == ST_RUN) && (!s1_valid_q || advance);
  assign accept   = in_valid && in_ready;
  assign s_in     = a_signed && b_signed;

`ifdef EXPR_EVAL_DIV_EN
  assign is_div = (s1_op_q == OP_DIV) || (s1_op_q == OP_MOD);
`else
  assign is_div = 1'b0;
`endif

  // Operands are already extended to RW, so every op below works in the result width.
  always_comb begin
    amt     = 64'(s1_b_q[WIDTH-1:0]);
    sh_over = (amt >= 64'(RW));
    lt      = s1_s_q ? ($signed(s1_a_q) < $signed(s1_b_q)) : (s1_a_q < s1_b_q);
    alu_res = '0;
    alu_err = 1'b0;
    case (s1_op_q)
      OP_ADD:  alu_res = s1_a_q + s1_b_q;
      OP_SUB:  alu_res = s1_a_q - s1_b_q;
      OP_MUL:  alu_res = s1_a_q * s1_b_q;
      OP_AND:  alu_res = s1_a_q & s1_b_q;
      OP_OR:   alu_res = s1_a_q | s1_b_q;
      OP_XNOR: alu_res = ~(s1_a_q ^ s1_b_q);
      OP_SHL:  alu_res = sh_over ? '0 : (s1_a_q << s1_b_q[WIDTH-1:0]);
      OP_SHR: begin
        if (sh_over)     alu_res = {RW{s1_s_q & s1_a_q[RW-1]}};
        else if (s1_s_q) alu_res = $signed(s1_a_q) >>> s1_b_q[WIDTH-1:0];
        else             alu_res = s1_a_q >> s1_b_q[WIDTH-1:0];
      end
      OP_LT:   alu_res = {{(RW-1){1'b0}}, lt};
      OP_EQ:   alu_res = {{(RW-1){1'b0}}, (s1_a_q == s1_b_q)};
      OP_RAND: alu_res = {{(RW-1){1'b0}}, &s1_a_q[WIDTH-1:0]};
      OP_RXOR: alu_res = {{(RW-1){1'b0}}, ^s1_a_q[WIDTH-1:0]};
      default: alu_err = 1'b1;
    endcase
  end

`ifdef EXPR_EVAL_DIV_EN
  // Restoring divide on magnitudes; signs are reapplied in RW bits so -2^(W-1)/-1 stays exact.
  always_comb begin
    ld_a_low = s1_a_q[WIDTH-1:0];
    ld_b_low = s1_b_q[WIDTH-1:0];
    ld_a_neg = s1_s_q & ld_a_low[WIDTH-1];
    ld_b_neg = s1_s_q & ld_b_low[WIDTH-1];
    ld_a_mag = ld_a_neg ? -ld_a_low : ld_a_low;
    ld_b_mag = ld_b_neg ? -ld_b_low : ld_b_low;
    rem_shift = {div_rem_q, div_quo_q[WIDTH-1]};
    trial     = rem_shift - {1'b0, div_den_q};
    if (trial[WIDTH]) begin
      rem_nx = rem_shift[WIDTH-1:0];
      quo_nx = {div_quo_q[WIDTH-2:0], 1'b0};
    end else begin
      rem_nx = trial[WIDTH-1:0];
      quo_nx = {div_quo_q[WIDTH-2:0], 1'b1};
    end
    q_ext = {{(RW-WIDTH){1'b0}}, quo_nx};
    r_ext = {{(RW-WIDTH){1'b0}}, rem_nx};
    if (div_zero_q)     div_res = div_mod_q ? div_a_q : '1;
    else if (div_mod_q) div_res = div_rneg_q ? -r_ext : r_ext;
    else                div_res = div_qneg_q ? -q_ext : q_ext;
  end
`endif

  always_comb begin
    state_d     = state_q;
    s1_valid_d  = s1_valid_q;
    s1_op_d     = s1_op_q;
    s1_s_d      = s1_s_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    err_d       = err_q;
`ifdef EXPR_EVAL_DIV_EN
    div_cnt_d  = div_cnt_q;
    div_rem_d  = div_rem_q;
    div_quo_d  = div_quo_q;
    div_den_d  = div_den_q;
    div_mod_d  = div_mod_q;
    div_qneg_d = div_qneg_q;
    div_rneg_d = div_rneg_q;
    div_zero_d = div_zero_q;
    div_a_d    = div_a_q;
`endif
    case (state_q)
      ST_RUN: begin
        if (advance) begin
          out_valid_d = 1'b0;
          if (s1_valid_q) begin
            s1_valid_d = 1'b0;
            if (is_div) begin
              state_d = ST_DIV;
`ifdef EXPR_EVAL_DIV_EN
              div_cnt_d  = '0;
              div_rem_d  = '0;
              div_quo_d  = ld_a_mag;
              div_den_d  = ld_b_mag;
              div_mod_d  = (s1_op_q == OP_MOD);
              div_qneg_d = ld_a_neg ^ ld_b_neg;
              div_rneg_d = ld_a_neg;
              div_zero_d = (ld_b_low == '0);
              div_a_d    = s1_a_q;
`endif
            end else begin
              out_valid_d = 1'b1;
              result_d    = alu_res;
              err_d       = alu_err;
            end
          end
        end
      end
`ifdef EXPR_EVAL_DIV_EN
      ST_DIV: begin
        div_cnt_d = div_cnt_q + 1'b1;
        div_rem_d = rem_nx;
        div_quo_d = quo_nx;
        if (div_cnt_q == CW'(WIDTH - 1)) begin
          state_d     = ST_DRAIN;
          out_valid_d = 1'b1;
          result_d    = div_res;
          err_d       = div_zero_q;
        end
      end
      ST_DRAIN: begin
        if (advance) begin
          out_valid_d = 1'b0;
          state_d     = ST_RUN;
        end
      end
`endif
      default: state_d = ST_RUN;
    endcase
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_op_d    = op_e'(op);
      s1_s_d     = s_in;
      s1_a_d     = {{(RW-WIDTH){s_in & a[WIDTH-1]}}, a};
      s1_b_d     = {{(RW-WIDTH){s_in & b[WIDTH-1]}}, b};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      s1_valid_q  <= 1'b0;
      s1_op_q     <= OP_ADD;
      s1_s_q      <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_s_q      <= s1_s_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      err_q       <= err_d;
    end
  end

`ifdef EXPR_EVAL_DIV_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_q  <= '0;
      div_rem_q  <= '0;
      div_quo_q  <= '0;
      div_den_q  <= '0;
      div_mod_q  <= 1'b0;
      div_qneg_q <= 1'b0;
      div_rneg_q <= 1'b0;
      div_zero_q <= 1'b0;
      div_a_q    <= '0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      div_rem_q  <= div_rem_d;
      div_quo_q  <= div_quo_d;
      div_den_q  <= div_den_d;
      div_mod_q  <= div_mod_d;
      div_qneg_q <= div_qneg_d;
      div_rneg_q <= div_rneg_d;
      div_zero_q <= div_zero_d;
      div_a_q    <= div_a_d;
    end
  end
`endif

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign err       = err_q;

endmodule

// File: tb/tb_expr_eval_pipe.sv
// Directed bench for expr_eval_pipe (WIDTH=8, RW=16); DIV/MOD expectations follow EXPR_EVAL_DIV_EN.
module tb_expr_eval_pipe;

`ifdef EXPR_EVAL_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  localparam int DIV_LAT = DIV_EN ? 10 : 2;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, a_signed, b_signed;
  logic        out_valid, out_ready, err;
  logic [3:0]  op;
  logic [7:0]  a, b;
  logic [15:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0]  vop [8];
  logic [7:0]  va  [8];
  logic [7:0]  vb  [8];
  logic        vas [8];
  logic        vbs [8];
  logic [15:0] vexp[8];

  always #5 clk = ~clk;

  expr_eval_pipe #(.WIDTH(8), .RW(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .a_signed(a_signed), .b(b), .b_signed(b_signed),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .err(err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [3:0] o, input logic [7:0] av, input logic as,
                        input logic [7:0] bv, input logic bs,
                        output logic [15:0] r, output logic e, output int lat);
    int guard;
    op = o; a = av; a_signed = as; b = bv; b_signed = bs;
    in_valid = 1'b1; out_ready = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin tick(); guard++; end
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 60) begin tick(); lat++; end
    r = result; e = err;
    tick();
  endtask

  task automatic do_op(input string tag, input logic [3:0] o, input logic [7:0] av, input logic as,
                       input logic [7:0] bv, input logic bs,
                       input logic [15:0] er, input logic ee, input int elat);
    logic [15:0] r; logic e; int lat;
    run_op(o, av, as, bv, bs, r, e, lat);
    check_eq({tag, ".res"}, 32'(r), 32'(er));
    check_eq({tag, ".err"}, 32'(e), 32'(ee));
    check_eq({tag, ".lat"}, 32'(lat), 32'(elat));
  endtask

  task automatic set_vec(input int i);
    op = vop[i]; a = va[i]; a_signed = vas[i]; b = vb[i]; b_signed = vbs[i];
  endtask

  task automatic burst(input string tag, input int n, input logic [31:0] stall,
                       output int cycles, output bit blocked);
    int sent, got; logic held, acc; logic [15:0] held_res;
    sent = 0; got = 0; cycles = 0; blocked = 1'b0; held = 1'b0; held_res = '0;
    set_vec(0);
    in_valid = 1'b1;
    while (got < n && cycles < 200) begin
      out_ready = (cycles < 32) ? !stall[cycles] : 1'b1;
      #1;
      if (held) check_eq({tag, ".hold"}, {15'd0, out_valid, result}, {15'd0, 1'b1, held_res});
      if (in_valid && !in_ready) blocked = 1'b1;
      held = out_valid && !out_ready;
      held_res = result;
      if (out_valid && out_ready) begin
        check_eq({tag, ".res"}, 32'(result), 32'(vexp[got]));
        got++;
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) sent++;
      cycles++;
      if (sent < n) set_vec(sent);
      else in_valid = 1'b0;
    end
    check_eq({tag, ".count"}, 32'(got), 32'(n));
    out_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, vcount; bit blk;
    rst_n = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0;
    a_signed = 1'b0; b_signed = 1'b0; out_ready = 1'b1;
    tick(); tick();
    check_eq("rst.out_valid", 32'(out_valid), 32'd0);
    check_eq("rst.result",    32'(result),    32'd0);
    check_eq("rst.err",       32'(err),       32'd0);
    check_eq("rst.in_ready",  32'(in_ready),  32'd0);
    rst_n = 1'b1;
    tick();
    check_eq("idle.in_ready", 32'(in_ready), 32'd1);

    do_op("add_ss",  4'd0,  8'hF0, 1, 8'h20, 1, 16'h0010, 0, 2);
    do_op("add_us",  4'd0,  8'hF0, 0, 8'h20, 1, 16'h0110, 0, 2);
    do_op("sub_uu",  4'd1,  8'h00, 0, 8'h01, 0, 16'hFFFF, 0, 2);
    do_op("mul_ss",  4'd2,  8'hFF, 1, 8'h02, 1, 16'hFFFE, 0, 2);
    do_op("and_ss",  4'd3,  8'hF0, 1, 8'h8F, 1, 16'hFF80, 0, 2);
    do_op("or_uu",   4'd4,  8'h01, 0, 8'h80, 0, 16'h0081, 0, 2);
    do_op("xnor_uu", 4'd5,  8'h0F, 0, 8'hF0, 0, 16'hFF00, 0, 2);
    do_op("shl_15",  4'd6,  8'h01, 0, 8'h0F, 0, 16'h8000, 0, 2);
    do_op("shl_16",  4'd6,  8'h01, 0, 8'h10, 0, 16'h0000, 0, 2);
    do_op("shr_big_s", 4'd7, 8'h80, 1, 8'h80, 1, 16'hFFFF, 0, 2);
    do_op("shr_big_u", 4'd7, 8'h80, 0, 8'h80, 1, 16'h0000, 0, 2);
    do_op("shr_3_s", 4'd7,  8'h80, 1, 8'h03, 1, 16'hFFF0, 0, 2);
    do_op("lt_ss",   4'd8,  8'hFF, 1, 8'h01, 1, 16'h0001, 0, 2);
    do_op("lt_uu",   4'd8,  8'hFF, 0, 8'h01, 0, 16'h0000, 0, 2);
    do_op("eq",      4'd9,  8'h5A, 0, 8'h5A, 0, 16'h0001, 0, 2);
    do_op("rand_ff", 4'd10, 8'hFF, 1, 8'h00, 0, 16'h0001, 0, 2);
    do_op("rand_fe", 4'd10, 8'hFE, 0, 8'h00, 0, 16'h0000, 0, 2);
    do_op("rxor_07", 4'd11, 8'h07, 0, 8'h00, 0, 16'h0001, 0, 2);
    do_op("illegal14", 4'd14, 8'h12, 0, 8'h34, 0, 16'h0000, 1, 2);
    do_op("illegal15", 4'd15, 8'hFF, 1, 8'hFF, 1, 16'h0000, 1, 2);

    do_op("div_m7_2",  4'd12, 8'hF9, 1, 8'h02, 1, DIV_EN ? 16'hFFFD : 16'h0000, !DIV_EN, DIV_LAT);
    do_op("mod_m7_2",  4'd13, 8'hF9, 1, 8'h02, 1, DIV_EN ? 16'hFFFF : 16'h0000, !DIV_EN, DIV_LAT);
    do_op("div_by0",   4'd12, 8'h05, 1, 8'h00, 1, DIV_EN ? 16'hFFFF : 16'h0000, 1, DIV_LAT);
    do_op("mod_by0",   4'd13, 8'hF9, 1, 8'h00, 1, DIV_EN ? 16'hFFF9 : 16'h0000, 1, DIV_LAT);
    do_op("div_min",   4'd12, 8'h80, 1, 8'hFF, 1, DIV_EN ? 16'h0080 : 16'h0000, !DIV_EN, DIV_LAT);
    do_op("div_uu",    4'd12, 8'hC8, 0, 8'h07, 0, DIV_EN ? 16'h001C : 16'h0000, !DIV_EN, DIV_LAT);

    for (int i = 0; i < 4; i++) begin
      vop[i] = 4'd2; va[i] = 8'hFF; vas[i] = 1'b0; vb[i] = 8'hFF; vbs[i] = 1'b0; vexp[i] = 16'hFE01;
    end
    burst("mul_stall", 4, 32'h0000_001C, cyc, blk);
    check_eq("mul_stall.blocked", 32'(blk), 32'd1);

    for (int i = 0; i < 6; i++) begin
      vop[i] = 4'd0; va[i] = 8'(i * 3 + 1); vas[i] = 1'b0; vb[i] = 8'h10; vbs[i] = 1'b0;
      vexp[i] = 16'(i * 3 + 1 + 16);
    end
    burst("add_order", 6, 32'h0000_0054, cyc, blk);
    burst("add_thru", 4, 32'h0, cyc, blk);
    check_eq("add_thru.cycles", 32'(cyc), 32'd6);
    check_eq("add_thru.blocked", 32'(blk), 32'd0);

    vop[0] = 4'd0;  va[0] = 8'h01; vas[0] = 0; vb[0] = 8'h02; vbs[0] = 0; vexp[0] = 16'h0003;
    vop[1] = 4'd12; va[1] = 8'h64; vas[1] = 0; vb[1] = 8'h07; vbs[1] = 0; vexp[1] = DIV_EN ? 16'h000E : 16'h0000;
    vop[2] = 4'd0;  va[2] = 8'h05; vas[2] = 0; vb[2] = 8'h05; vbs[2] = 0; vexp[2] = 16'h000A;
    burst("mixed_order", 3, 32'h0000_0008, cyc, blk);

    op = 4'd12; a = 8'h64; a_signed = 1'b0; b = 8'h07; b_signed = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    check_eq("rst_div.out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_div.result",    32'(result),    32'd0);
    check_eq("rst_div.in_ready",  32'(in_ready),  32'd0);
    rst_n = 1'b1;
    vcount = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (out_valid) vcount++;
    end
    check_eq("rst_div.no_result", 32'(vcount), 32'd0);
    do_op("add_after_rst", 4'd0, 8'h01, 0, 8'h01, 0, 16'h0002, 0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/expr_eval_pipe.md
Name: expr_eval_pipe

Overview:
- Parametrised, registered successor to the flat combinational expression blocks.
- Evaluates one binary or unary Verilog-semantics expression per accepted transaction on WIDTH-bit operands.
- Each operand carries its own signedness flag; the result is width-extended exactly as the language rules require.
- Sits between the stimulus generator and the scoreboard: valid/ready in and out, 2-stage pipeline, iterative divider for DIV/MOD.

Parameters:
- WIDTH, 8, operand width in bits (2..32).
- RW, 2*WIDTH, result width; must be >= 2*WIDTH.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operand transaction valid.
- in_ready  out  1  block can accept this cycle.
- op  in  4  opcode (see Behaviour).
- a  in  WIDTH  operand A.
- a_signed  in  1  A is a signed operand.
- b  in  WIDTH  operand B.
- b_signed  in  1  B is a signed operand.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  RW  expression value.
- err  out  1  illegal opcode or divide by zero, qualified by out_valid.

Behaviour:
- Handshake: accept when in_valid && in_ready; result transfers when out_valid && out_ready.
  - result and err hold stable while out_valid && !out_ready.
- Reset (rst_n low at a clock edge): out_valid=0, result=0, err=0, in_ready=0 that cycle, S1 and divider flushed, state=RUN.
  - Reset mid-divide aborts the divide; no result is emitted.
- Expression signedness S = a_signed && b_signed.
  - Each operand is extended to RW bits: sign-extended if S, zero-extended otherwise. This happens before evaluation.
  - Unary ops use a_signed alone.
- Opcodes:
  - 0 ADD, 1 SUB, 2 MUL: result mod 2^RW.
  - 3 AND, 4 OR, 5 XNOR.
  - 6 SHL: logical; shift amount = b unsigned; amount >= RW gives 0.
  - 7 SHR: arithmetic if S, else logical; amount >= RW gives all sign bits (S) or 0.
  - 8 LT, 9 EQ: 1-bit result, zero-extended.
  - 10 RED_AND (&a), 11 RED_XOR (^a): over the WIDTH bits of a only; 1-bit result, zero-extended.
  - 12 DIV, 13 MOD: truncate toward zero; remainder takes the dividend's sign.
  - 14, 15 illegal: result=0, err=1.
- Divide by zero: DIV gives all-ones; MOD gives the extended a; err=1.
- Pipeline (non-divide ops):
  - S1 captures operands; S2 holds result/err.
  - advance = !out_valid || out_ready.
  - Latency 2 cycles accept-to-out_valid; throughput 1/cycle while out_ready=1.
  - in_ready = (state==RUN) && (!s1_valid || advance).
- State machine RUN/DIV/DRAIN:
  - RUN→DIV when S1 holds DIV/MOD and advance.
  - In DIV: restoring divider on magnitudes, one quotient bit/cycle, WIDTH cycles, in_ready=0.
  - DIV→DRAIN on the last bit: apply signs, write S2, out_valid=1.
  - DRAIN→RUN when out_valid drops or advance.
  - DIV/MOD latency: WIDTH+2 cycles accept-to-out_valid when out_ready=1.
- Simultaneous accept and output handshake in the same cycle is legal; no bubble is inserted.
- Ordering: results exit strictly in acceptance order.

Optional Feature:
- Macro EXPR_EVAL_DIV_EN.
- Defined: DIV/MOD and the DIV/DRAIN states exist as described above.
- Undefined: no divider logic. Opcodes 12 and 13 behave as illegal (result=0, err=1, latency 2), and the state machine stays in RUN.

Test Plan:
- WIDTH=8. ADD, a=0xF0 signed, b=0x20 signed → result 0x0010, err=0, out_valid 2 cycles after accept.
- WIDTH=8. ADD, a=0xF0 unsigned, b=0x20 signed → S=0, zero-extension, result 0x0110.
- WIDTH=8. SHR, a=0x80 signed, b=0x80 signed, amount 128 → 0xFFFF; same operands with a_signed=0 → 0x0000.
- WIDTH=8, EXPR_EVAL_DIV_EN defined:
  - DIV a=-7, b=2, both signed → 0xFFFD after 10 cycles.
  - MOD same operands → 0xFFFF.
  - DIV b=0 → 0xFFFF, err=1.
- Back-to-back MUL 0xFF*0xFF unsigned ×4 with out_ready low for 3 cycles → result 0xFE01 held stable, in_ready drops, four results in order, no loss.
- rst_n low during cycle 4 of a DIV → next cycle out_valid=0, result=0; a subsequent ADD 1+1 → 0x0002 with normal latency.
